// File: rtl/base_agather.sv
// base_agather: valid/ready gathering deserializer.
// Collects `ways` narrow beats of `width` bits each and emits them as one wide word.
// Packing is big-endian: the first beat lands in o_d[0:width-1].
// The accumulator and the output register are separate, so a new word can start
// while the previous one is still waiting to be consumed.
module base_agather #(
    parameter int width = 1,
    parameter int ways  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_v,
    output logic                     i_r,
    input  logic [0:width-1]         i_d,
    output logic                     o_v,
    input  logic                     o_r,
    output logic [0:width*ways-1]    o_d,
    output logic [0:$clog2(ways)-1]  o_cnt
);

    localparam int CW = $clog2(ways);
    localparam int AW = width * (ways - 1);
    localparam logic [CW-1:0] LAST = CW'(ways - 1);

    // Reject degenerate configurations at elaboration time.
    if (ways < 2 || width < 1) begin : g_bad_params
        $error("base_agather: ways must be >= 2 and width must be >= 1");
    end

    logic [CW-1:0]     cnt;
    logic [0:AW-1]     acc;
    logic [0:width*ways-1] word_q;
    logic              valid_q;

    logic at_last;
    logic take;
    logic drain;

    // Handshake decode. i_r depends only on state and o_r, never on i_v.
    // The last beat of a word may only enter when the output register is free
    // or is being drained in this same cycle.
    always_comb begin
        at_last = (cnt == LAST);
        i_r     = reset & (~at_last | ~valid_q | o_r);
        take    = i_v & i_r;
        drain   = valid_q & o_r;
    end

    // Beat counter: position of the next beat within the word, wraps after the last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (take) begin
            if (at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Accumulator: stores beats 0..ways-2 in their big-endian slots.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (take && !at_last) begin
            for (int k = 0; k < ways - 1; k++) begin
                if (cnt == CW'(k)) begin
                    acc[k*width +: width] <= i_d;
                end
            end
        end
    end

    // Output register: the last beat bypasses the accumulator and the full word
    // loads here; a simultaneous load and consume keeps o_v high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (take && at_last) begin
            valid_q <= 1'b1;
            word_q  <= {acc, i_d};
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign o_v   = valid_q;
    assign o_d   = word_q;
    assign o_cnt = cnt;

endmodule
